puzzle_ctrl: RTL and testbench

// - Game controller for the 2x2 image puzzle. Sits directly upstream of the VGA renderer.
// - Debounces five push-buttons, shuffles the four tiles with an LFSR and applies player moves.
// - Drives img_nums, the tile-to-quadrant map consumed by the renderer, and flags the solved state.
// - Field layout: [11:9]=a (top-left), [8:6]=b (top-right), [5:3]=c (bottom-left), [2:0]=d (bottom-right).

---
 rtl/puzzle_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_puzzle_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/puzzle_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : puzzle_ctrl
// Summary  : 2x2 image puzzle controller. It debounces five buttons, shuffles
//            the tiles with an LFSR and applies player moves to img_nums.
//            Define BLANK_TILE_EN for sliding mode. The default is swap mode.
// Revision : 1.0  initial release
// =============================================================================
module puzzle_ctrl #(
    parameter int          DEBOUNCE_CYCLES = 1_000_000,
    parameter int          SHUFFLE_STEPS   = 32,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_center,
    output logic [11:0] img_nums,
    output logic [1:0]  cursor_pos,
    output logic        selected,
    output logic        solved,
    output logic [7:0]  move_cnt
);

    localparam int          CW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int          SW        = $clog2(SHUFFLE_STEPS + 1);
    localparam logic [CW-1:0] C_DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] C_SH_LAST = SW'(SHUFFLE_STEPS);
    localparam logic [11:0] C_SOLVED  = 12'h053;
`ifdef BLANK_TILE_EN
    localparam bit          C_SLIDING = 1'b1;
`else
    localparam bit          C_SLIDING = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHUFFLE = 2'd1,
        S_PLAY    = 2'd2,
        S_SOLVED  = 2'd3
    } state_t;

    function automatic logic [2:0] f_get(input logic [11:0] l, input logic [1:0] p);
        case (p)
            2'd0:    f_get = l[11:9];
            2'd1:    f_get = l[8:6];
            2'd2:    f_get = l[5:3];
            default: f_get = l[2:0];
        endcase
    endfunction

    function automatic logic [11:0] f_put(input logic [11:0] l, input logic [1:0] p,
                                          input logic [2:0] v);
        logic [11:0] r;
        r = l;
        case (p)
            2'd0:    r[11:9] = v;
            2'd1:    r[8:6]  = v;
            2'd2:    r[5:3]  = v;
            default: r[2:0]  = v;
        endcase
        return r;
    endfunction

    // Both fields are read from the old layout, so the result is always a permutation.
    function automatic logic [11:0] f_swap(input logic [11:0] l, input logic [1:0] p,
                                           input logic [1:0] q);
        return f_put(f_put(l, p, f_get(l, q)), q, f_get(l, p));
    endfunction

`ifdef BLANK_TILE_EN
    function automatic logic [1:0] f_blank_pos(input logic [11:0] l);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (f_get(l, 2'(k)) == 3'd3) r = 2'(k);
        end
        return r;
    endfunction

    function automatic logic [11:0] f_present(input logic [11:0] l);
        logic [11:0] r;
        r = l;
        for (int k = 0; k < 4; k++) begin
            if (f_get(l, 2'(k)) == 3'd3) r = f_put(r, 2'(k), 3'b100);
        end
        return r;
    endfunction
`endif

    // ---------------------------------------------------------------- debounce
    logic [4:0] w_raw;
    logic [4:0] w_pulse;

    assign w_raw = {btn_center, btn_up, btn_down, btn_left, btn_right};

    for (genvar gi = 0; gi < 5; gi++) begin : g_db
        logic [1:0]    r_sync;
        logic          r_level;
        logic [CW-1:0] r_cnt;
        logic          r_pulse;

        // r_level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_ff @(posedge sys_clk or posedge rst) begin
            if (rst) begin
                r_sync  <= 2'b00;
                r_level <= 1'b0;
                r_cnt   <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_sync  <= {r_sync[0], w_raw[gi]};
                r_pulse <= 1'b0;
                if (r_sync[1] == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == C_DB_LAST) begin
                    r_cnt   <= '0;
                    r_level <= r_sync[1];
                    r_pulse <= r_sync[1];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_pulse[gi] = r_pulse;
    end

    logic w_center, w_up, w_down, w_left, w_right;

    assign w_center = w_pulse[4];
    assign w_up     = w_pulse[3] & ~w_pulse[4];
    assign w_down   = w_pulse[2] & ~|w_pulse[4:3];
    assign w_left   = w_pulse[1] & ~|w_pulse[4:2];
    assign w_right  = w_pulse[0] & ~|w_pulse[4:1];

    // -------------------------------------------------------------------- lfsr
    logic [15:0] r_lfsr;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) r_lfsr <= LFSR_SEED;
        else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    // --------------------------------------------------------------------- fsm
    state_t        r_state;
    logic [11:0]   r_img;
    logic [1:0]    r_cursor;
    logic [1:0]    r_mpos;
    logic          r_sel;
    logic          r_solved;
    logic [7:0]    r_move_cnt;
    logic [SW-1:0] r_step;

    logic [1:0]  w_nb;
    logic        w_legal;
    logic [11:0] w_play_swap;
    logic        w_play_solved;
    logic [1:0]  w_sh_nb;
    logic [11:0] w_sh_swap;
    logic [1:0]  w_start_pos;
    logic [1:0]  w_exit_cursor;
    logic [7:0]  w_cnt_inc;

    // Bit 1 of a position is the row and bit 0 is the column. A legal move toggles exactly one of them.
    assign w_nb          = (w_up | w_down) ? (r_cursor ^ 2'b10) : (r_cursor ^ 2'b01);
    assign w_legal       = (w_up & r_cursor[1]) | (w_down & ~r_cursor[1]) |
                           (w_left & r_cursor[0]) | (w_right & ~r_cursor[0]);
    assign w_play_swap   = f_swap(r_img, r_cursor, w_nb);
    assign w_play_solved = (w_play_swap == C_SOLVED);
    assign w_sh_nb       = r_lfsr[0] ? (r_mpos ^ 2'b10) : (r_mpos ^ 2'b01);
    assign w_sh_swap     = f_swap(r_img, r_mpos, w_sh_nb);
    assign w_cnt_inc     = (r_move_cnt == 8'hFF) ? 8'hFF : (r_move_cnt + 8'd1);

`ifdef BLANK_TILE_EN
    assign w_start_pos   = f_blank_pos(r_img);
    assign w_exit_cursor = r_mpos;
    assign img_nums      = (r_state == S_SHUFFLE || r_state == S_PLAY) ? f_present(r_img) : r_img;
`else
    assign w_start_pos   = 2'd0;
    assign w_exit_cursor = 2'd0;
    assign img_nums      = r_img;
`endif

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_img      <= C_SOLVED;
            r_cursor   <= 2'd0;
            r_mpos     <= 2'd0;
            r_sel      <= 1'b0;
            r_solved   <= 1'b1;
            r_move_cnt <= 8'd0;
            r_step     <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_SOLVED: begin
                    r_sel <= 1'b0;
                    if (w_center) begin
                        r_state    <= S_SHUFFLE;
                        r_step     <= '0;
                        r_move_cnt <= 8'd0;
                        r_mpos     <= w_start_pos;
                    end
                end
                S_SHUFFLE: begin
                    // Shuffle steps continue past the budget while the layout is still solved.
                    if (r_step != C_SH_LAST || r_img == C_SOLVED) begin
                        r_img    <= w_sh_swap;
                        r_mpos   <= w_sh_nb;
                        r_solved <= (w_sh_swap == C_SOLVED);
                        if (r_step != C_SH_LAST) r_step <= r_step + 1'b1;
                    end else begin
                        r_state  <= S_PLAY;
                        r_cursor <= w_exit_cursor;
                        r_sel    <= 1'b0;
                    end
                end
                S_PLAY: begin
                    if (w_center) begin
                        if (!C_SLIDING) r_sel <= ~r_sel;
                    end else if (w_legal) begin
                        r_cursor <= w_nb;
                        if (C_SLIDING || r_sel) begin
                            r_img      <= w_play_swap;
                            r_solved   <= w_play_solved;
                            r_move_cnt <= w_cnt_inc;
                            if (w_play_solved) begin
                                r_state <= S_SOLVED;
                                r_sel   <= 1'b0;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cursor_pos = r_cursor;
    assign selected   = r_sel;
    assign solved     = r_solved;
    assign move_cnt   = r_move_cnt;

endmodule
`default_nettype wire

// File: tb/tb_puzzle_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_puzzle_ctrl
// Summary  : Self-checking bench for puzzle_ctrl in swap mode. It holds a
//            tile/cursor reference model and drives directed and random moves.
// Revision : 1.0  initial release
// =============================================================================
module tb_puzzle_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  btn;   // [4]=center [3]=up [2]=down [1]=left [0]=right
    logic [11:0] img_nums;
    logic [1:0]  cursor_pos;
    logic        selected;
    logic        solved;
    logic [7:0]  move_cnt;

    int vectors = 0;
    int errors  = 0;

    // reference model: tile code per quadrant, cursor row/col, game mode
    int tiles[4];
    int cur_r, cur_c;
    bit sel;
    int mcnt;
    int mstate;   // 0 idle, 1 play, 2 solved

    puzzle_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .SHUFFLE_STEPS  (32),
        .LFSR_SEED      (16'hACE1)
    ) u_dut (
        .sys_clk   (clk),
        .rst       (rst),
        .btn_up    (btn[3]),
        .btn_down  (btn[2]),
        .btn_left  (btn[1]),
        .btn_right (btn[0]),
        .btn_center(btn[4]),
        .img_nums  (img_nums),
        .cursor_pos(cursor_pos),
        .selected  (selected),
        .solved    (solved),
        .move_cnt  (move_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] pack(input int t[4]);
        logic [11:0] v;
        for (int k = 0; k < 4; k++) v[9-3*k +: 3] = 3'(t[k]);
        return v;
    endfunction

    function automatic logic [11:0] model_img();
        return pack(tiles);
    endfunction

    function automatic logic [11:0] swap_result(input int b);
        int t[4];
        int p, q, x;
        t = tiles;
        p = cur_r * 2 + cur_c;
        q = (b >= 2) ? (p ^ 2) : (p ^ 1);
        x = t[p]; t[p] = t[q]; t[q] = x;
        return pack(t);
    endfunction

    task automatic model_reset();
        tiles  = '{0, 1, 2, 3};
        cur_r  = 0;
        cur_c  = 0;
        sel    = 1'b0;
        mcnt   = 0;
        mstate = 0;
    endtask

    task automatic model_dir(input int b);
        int  r, c, p, q, x;
        bit  legal;
        if (mstate != 1) return;
        case (b)
            3:       legal = (cur_r == 1);
            2:       legal = (cur_r == 0);
            1:       legal = (cur_c == 1);
            default: legal = (cur_c == 0);
        endcase
        if (!legal) return;
        r = (b >= 2) ? 1 - cur_r : cur_r;
        c = (b >= 2) ? cur_c : 1 - cur_c;
        if (sel) begin
            p = cur_r * 2 + cur_c;
            q = r * 2 + c;
            x = tiles[p]; tiles[p] = tiles[q]; tiles[q] = x;
            if (mcnt < 255) mcnt++;
        end
        cur_r = r;
        cur_c = c;
        if (sel && model_img() == 12'h053) begin
            mstate = 2;
            sel    = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".img"},    32'(img_nums),   32'(model_img()));
        chk({tag, ".cursor"}, 32'(cursor_pos), 32'(cur_r * 2 + cur_c));
        chk({tag, ".sel"},    32'(selected),   32'(sel));
        chk({tag, ".cnt"},    32'(move_cnt),   32'(mcnt));
        chk({tag, ".solved"}, 32'(solved),     32'(model_img() == 12'h053));
    endtask

    task automatic press(input int b);
        @(negedge clk);
        btn[b] = 1'b1;
        repeat (8) @(negedge clk);
        btn[b] = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // one button press applied to both DUT and model, then full compare
    task automatic act(input int b, input string tag);
        press(b);
        if (b == 4) begin
            if (mstate == 1) sel = !sel;
        end else begin
            model_dir(b);
        end
        check_all(tag);
    endtask

    // legal swap direction from the cursor that does not land on the solved layout
    task automatic pick_dir(output int b);
        int opts[2];
        int k;
        opts[0] = (cur_r == 0) ? 2 : 3;
        opts[1] = (cur_c == 0) ? 0 : 1;
        k = $urandom_range(0, 1);
        b = opts[k];
        if (swap_result(b) == 12'h053) b = opts[1-k];
    endtask

    task automatic do_shuffle(input string tag);
        logic [7:0] seen;
        press(4);
        repeat (40) @(negedge clk);
        mstate = 1; sel = 1'b0; cur_r = 0; cur_c = 0; mcnt = 0;
        chk({tag, ".solved"},   32'(solved),               32'd0);
        chk({tag, ".cnt"},      32'(move_cnt),             32'd0);
        chk({tag, ".cursor"},   32'(cursor_pos),           32'd0);
        chk({tag, ".sel"},      32'(selected),             32'd0);
        chk({tag, ".scrambled"}, 32'(img_nums != 12'h053), 32'd1);
        seen = 8'd0;
        for (int k = 0; k < 4; k++) seen[img_nums[9-3*k +: 3]] = 1'b1;
        chk({tag, ".perm"}, 32'(seen), 32'h0F);
        // the random layout becomes the model's starting point
        for (int k = 0; k < 4; k++) tiles[k] = int'(img_nums[9-3*k +: 3]);
    endtask

    initial begin
        int  b;
        bit  reached;

        btn = 5'd0;
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all("reset");

        act(0, "idle_right");
        do_shuffle("shuffle1");

        // glitch shorter than the debounce window
        @(negedge clk);
        btn[0] = 1'b1;
        repeat (3) @(negedge clk);
        btn[0] = 1'b0;
        repeat (12) @(negedge clk);
        check_all("glitch");

        // long hold yields exactly one move
        btn[0] = 1'b1;
        repeat (10) @(negedge clk);
        btn[0] = 1'b0;
        repeat (10) @(negedge clk);
        model_dir(0);
        check_all("hold_right");

        act(1, "left_back");
        act(1, "left_at_0");
        act(3, "up_at_0");

        // random adjacent transpositions until the layout is 12'h213
        reached = (model_img() == 12'h213);
        for (int s = 0; s < 300 && !reached; s++) begin
            if ($urandom_range(0, 1) == 1) begin
                b = (cur_c == 0) ? 0 : 1;
                if ($urandom_range(0, 1) == 1) b = (cur_r == 0) ? 2 : 3;
                act(b, "walk_move");
            end
            act(4, "walk_sel");
            pick_dir(b);
            act(b, "walk_swap");
            act(4, "walk_unsel");
            reached = (model_img() == 12'h213);
        end
        assert (reached) else begin
            errors++;
            $error("FAIL walk_bound: observed %0h expected %0h", model_img(), 12'h213);
        end

        while (cur_r != 0 || cur_c != 0) act((cur_c == 1) ? 1 : 3, "to_origin");
        act(4, "select");
        act(0, "solve_right");
        chk("solve_right.state_solved", 32'(solved), 32'd1);
        chk("solve_right.layout",       32'(img_nums), 32'h053);
        act(1, "solved_left");

        do_shuffle("shuffle2");
        act(4, "sat_select");
        for (int i = 0; i < 300; i++) begin
            pick_dir(b);
            act(b, "sat_swap");
            if (i % 25 == 0) act((cur_r == 0) ? 3 : 2, "sat_illegal");
        end
        chk("sat_final", 32'(move_cnt), 32'd255);

        // asynchronous reset in the middle of a shuffle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset2");
        btn[4] = 1'b1;
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all("async_rst");
        btn[4] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_all("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
